rcu_preg_alloc: RTL

- Physical-register allocation controller in the RCU; sits directly downstream of the free-list FIFO (f2if2o instance, FIFO_DATA_WIDTH=PREG_WIDTH) and drives both its read and write ports.
- After reset it seeds the free list with pregs ARCH_REG_NUM..PREG_NUM-1. It then serves up to two rename allocations and accepts up to two commit-side frees per cycle.
- Lanes are always compacted onto the FIFO first port, because a second-port-only FIFO access is never legal.

---
 rtl/rcu_preg_alloc_pkg.sv | 38 +++
 rtl/rcu_preg_alloc_if.sv | 60 ++++++
 rtl/rcu_lane_compact.sv | 31 +++
 rtl/rcu_preg_alloc.sv | 138 +++++++++++++
 4 files changed

// File: rtl/rcu_preg_alloc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rcu_preg_alloc_pkg
// Brief    : Shared constants, state enum and 2-lane compaction helper for
//            the RCU physical-register allocator.
// Revision : 1.0 - initial release
// ============================================================================
package rcu_preg_alloc_pkg;

  localparam int PREG_NUM        = 64;
  localparam int PREG_WIDTH      = 6;
  localparam int ARCH_REG_NUM    = 32;
  // Free-list depth equals the number of pregs not initially mapped.
  localparam int FIFO_SIZE       = PREG_NUM - ARCH_REG_NUM;
  localparam int FIFO_SIZE_WIDTH = 5;

  typedef enum logic [0:0] {
    INIT = 1'b0,
    RUN  = 1'b1
  } alloc_state_e;

  typedef struct packed {
    logic lane0_en;
    logic lane1_en;
    logic lane0_sel;   // lane 0 carries lane-1 data
  } compact_t;

  // A lone request on lane 1 is moved onto lane 0.
  function automatic compact_t lane_compact(input logic v0, input logic v1);
    compact_t c;
    c.lane0_en  = v0 | v1;
    c.lane1_en  = v0 & v1;
    c.lane0_sel = ~v0 & v1;
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rcu_preg_alloc_if.sv
`default_nettype none
// ============================================================================
// Module   : rcu_preg_alloc_if
// Brief    : Rename, commit and free-list FIFO signals of the preg allocator.
// Revision : 1.0 - initial release
// ============================================================================
interface rcu_preg_alloc_if;
  import rcu_preg_alloc_pkg::*;

  logic                       rn_valid_first_i;
  logic                       rn_valid_second_i;
  logic [4:0]                 rn_rd_first_i;
  logic [4:0]                 rn_rd_second_i;
  logic                       rn_ready_o;
  logic                       rn_alloc_first_o;
  logic                       rn_alloc_second_o;
  logic [PREG_WIDTH-1:0]      rn_preg_first_o;
  logic [PREG_WIDTH-1:0]      rn_preg_second_o;
  logic                       cm_free_first_i;
  logic                       cm_free_second_i;
  logic [PREG_WIDTH-1:0]      cm_preg_first_i;
  logic [PREG_WIDTH-1:0]      cm_preg_second_i;
  logic                       fl_rd_first_en_o;
  logic                       fl_rd_second_en_o;
  logic [PREG_WIDTH-1:0]      fl_rdata_first_i;
  logic [PREG_WIDTH-1:0]      fl_rdata_second_i;
  logic                       fl_wr_first_en_o;
  logic                       fl_wr_second_en_o;
  logic [PREG_WIDTH-1:0]      fl_wdata_first_o;
  logic [PREG_WIDTH-1:0]      fl_wdata_second_o;
  logic [FIFO_SIZE_WIDTH:0]   fl_num_i;
  logic                       init_done_o;
  logic                       err_overflow_o;

  modport slave (
    input  rn_valid_first_i, rn_valid_second_i, rn_rd_first_i, rn_rd_second_i,
    output rn_ready_o, rn_alloc_first_o, rn_alloc_second_o,
    output rn_preg_first_o, rn_preg_second_o,
    input  cm_free_first_i, cm_free_second_i, cm_preg_first_i, cm_preg_second_i,
    output fl_rd_first_en_o, fl_rd_second_en_o,
    input  fl_rdata_first_i, fl_rdata_second_i,
    output fl_wr_first_en_o, fl_wr_second_en_o, fl_wdata_first_o, fl_wdata_second_o,
    input  fl_num_i,
    output init_done_o, err_overflow_o
  );

  modport master (
    output rn_valid_first_i, rn_valid_second_i, rn_rd_first_i, rn_rd_second_i,
    input  rn_ready_o, rn_alloc_first_o, rn_alloc_second_o,
    input  rn_preg_first_o, rn_preg_second_o,
    output cm_free_first_i, cm_free_second_i, cm_preg_first_i, cm_preg_second_i,
    input  fl_rd_first_en_o, fl_rd_second_en_o,
    output fl_rdata_first_i, fl_rdata_second_i,
    input  fl_wr_first_en_o, fl_wr_second_en_o, fl_wdata_first_o, fl_wdata_second_o,
    output fl_num_i,
    input  init_done_o, err_overflow_o
  );

endinterface
`default_nettype wire

// File: rtl/rcu_lane_compact.sv
`default_nettype none
// ============================================================================
// Module   : rcu_lane_compact
// Brief    : 2-to-2 valid/data packer; a lone lane-1 request moves to lane 0.
// Revision : 1.0 - initial release
// ============================================================================
module rcu_lane_compact
  import rcu_preg_alloc_pkg::*;
#(
  parameter int WIDTH = PREG_WIDTH
) (
  input  logic             i_v0,
  input  logic             i_v1,
  input  logic [WIDTH-1:0] i_d0,
  input  logic [WIDTH-1:0] i_d1,
  output logic             o_en0,
  output logic             o_en1,
  output logic [WIDTH-1:0] o_q0,
  output logic [WIDTH-1:0] o_q1
);

  compact_t w_c;

  assign w_c   = lane_compact(i_v0, i_v1);
  assign o_en0 = w_c.lane0_en;
  assign o_en1 = w_c.lane1_en;
  assign o_q0  = w_c.lane0_sel ? i_d1 : i_d0;
  assign o_q1  = i_d1;

endmodule
`default_nettype wire

// File: rtl/rcu_preg_alloc.sv
`default_nettype none
// ============================================================================
// Module   : rcu_preg_alloc
// Brief    : Seeds the free-list FIFO after reset, then serves two rename
//            allocations and two commit frees per cycle.
// Revision : 1.0 - initial release
// ============================================================================
module rcu_preg_alloc
  import rcu_preg_alloc_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  rcu_preg_alloc_if.slave bus
);

  localparam logic [PREG_WIDTH-1:0] C_SEED_LAST = PREG_WIDTH'(PREG_NUM - 2);
  localparam int                    LVL_W       = FIFO_SIZE_WIDTH + 2;

  alloc_state_e          r_state;
  alloc_state_e          w_state_nxt;
  logic [PREG_WIDTH-1:0] r_cnt;
  logic                  r_err;

  logic                  w_need_f, w_need_s, w_any_free;
  logic                  w_ready, w_fire, w_overflow, w_drop;
  logic [1:0]            w_needs, w_pops, w_frees;
  logic [LVL_W-1:0]      w_level;
  logic                  w_pop_en0, w_pop_en1, w_push_en0, w_push_en1;
  logic [PREG_WIDTH-1:0] w_pop_q0, w_pop_q1, w_push_q0, w_push_q1;

  assign w_need_f   = bus.rn_valid_first_i  & (bus.rn_rd_first_i  != 5'd0);
  assign w_need_s   = bus.rn_valid_second_i & (bus.rn_rd_second_i != 5'd0);
  assign w_needs    = {1'b0, w_need_f} + {1'b0, w_need_s};
  assign w_frees    = {1'b0, bus.cm_free_first_i} + {1'b0, bus.cm_free_second_i};
  assign w_any_free = bus.cm_free_first_i | bus.cm_free_second_i;

  // Data lanes are swapped on the pop side: q1 is always FIFO head (slot
  // first), q0 is the head when slot second pops alone, else the next entry.
  rcu_lane_compact #(.WIDTH(PREG_WIDTH)) u_pop_compact (
    .i_v0  (w_need_f),
    .i_v1  (w_need_s),
    .i_d0  (bus.fl_rdata_second_i),
    .i_d1  (bus.fl_rdata_first_i),
    .o_en0 (w_pop_en0),
    .o_en1 (w_pop_en1),
    .o_q0  (w_pop_q0),
    .o_q1  (w_pop_q1)
  );

  rcu_lane_compact #(.WIDTH(PREG_WIDTH)) u_push_compact (
    .i_v0  (bus.cm_free_first_i),
    .i_v1  (bus.cm_free_second_i),
    .i_d0  (bus.cm_preg_first_i),
    .i_d1  (bus.cm_preg_second_i),
    .o_en0 (w_push_en0),
    .o_en1 (w_push_en1),
    .o_q0  (w_push_q0),
    .o_q1  (w_push_q1)
  );

  always_comb begin
    w_state_nxt           = r_state;
    w_ready               = 1'b0;
    w_fire                = 1'b0;
    w_pops                = 2'd0;
    w_level               = '0;
    w_overflow            = 1'b0;
    w_drop                = 1'b0;
    bus.rn_ready_o        = 1'b0;
    bus.rn_alloc_first_o  = 1'b0;
    bus.rn_alloc_second_o = 1'b0;
    bus.rn_preg_first_o   = '0;
    bus.rn_preg_second_o  = '0;
    bus.fl_rd_first_en_o  = 1'b0;
    bus.fl_rd_second_en_o = 1'b0;
    bus.fl_wr_first_en_o  = 1'b0;
    bus.fl_wr_second_en_o = 1'b0;
    bus.fl_wdata_first_o  = '0;
    bus.fl_wdata_second_o = '0;
    if (!rst) begin
      case (r_state)
        INIT: begin
          bus.fl_wr_first_en_o  = 1'b1;
          bus.fl_wr_second_en_o = 1'b1;
          bus.fl_wdata_first_o  = r_cnt;
          bus.fl_wdata_second_o = r_cnt + PREG_WIDTH'(1);
          w_drop                = w_any_free;
          if (r_cnt == C_SEED_LAST) begin
            w_state_nxt = RUN;
          end
        end
        RUN: begin
          // Ready looks only at pre-cycle occupancy; same-cycle frees are not bypassed.
          w_ready    = bus.fl_num_i >= (FIFO_SIZE_WIDTH+1)'(w_needs);
          w_fire     = w_ready & (bus.rn_valid_first_i | bus.rn_valid_second_i);
          w_pops     = w_fire ? w_needs : 2'd0;
          w_level    = LVL_W'(bus.fl_num_i) - LVL_W'(w_pops) + LVL_W'(w_frees);
          w_overflow = w_level > LVL_W'(FIFO_SIZE);
          w_drop     = w_any_free & w_overflow;

          bus.rn_ready_o        = w_ready;
          bus.rn_alloc_first_o  = w_need_f & w_fire;
          bus.rn_alloc_second_o = w_need_s & w_fire;
          bus.rn_preg_first_o   = (w_need_f & w_fire) ? w_pop_q1 : '0;
          bus.rn_preg_second_o  = (w_need_s & w_fire) ? w_pop_q0 : '0;
          bus.fl_rd_first_en_o  = w_pop_en0 & w_fire;
          bus.fl_rd_second_en_o = w_pop_en1 & w_fire;
          if (!w_overflow) begin
            bus.fl_wr_first_en_o  = w_push_en0;
            bus.fl_wr_second_en_o = w_push_en1;
            bus.fl_wdata_first_o  = w_push_q0;
            bus.fl_wdata_second_o = w_push_q1;
          end
        end
        default: w_state_nxt = INIT;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= INIT;
      r_cnt   <= PREG_WIDTH'(ARCH_REG_NUM);
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == INIT) begin
        r_cnt <= r_cnt + PREG_WIDTH'(2);
      end
      r_err <= r_err | w_drop;
    end
  end

  assign bus.init_done_o    = (r_state == RUN);
  assign bus.err_overflow_o = r_err;

endmodule
`default_nettype wire
